unpool_engine: RTL and testbench

- Nearest-neighbour 2x upsampler; the inverse of the 2x2 max-pool stage on the same signed 8-bit raster pixel stream.
- Consumes an IN_DIM x IN_DIM feature map row-major and emits an OUT_DIM x OUT_DIM map: every pixel duplicated horizontally, every row duplicated vertically.
- Sits on the decoder/upsampling path, between a pooled-map producer and the next convolution engine. Valid/ready handshakes on both sides.

---
 rtl/unpool_engine_if.sv | 21 ++
 rtl/unpool_engine.sv | 170 +++++++++++++++++
 tb/tb_unpool_engine.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/unpool_engine_if.sv
// Pixel-stream bundle for unpool_engine: upstream pixels in, upsampled pixels out, frame-done flag.
// The engine takes the slave side; whatever drives and consumes the streams takes the master side.
interface unpool_engine_if;
  logic              valid_in;
  logic              ready_in;
  logic signed [7:0] pixel_in;
  logic              valid_out;
  logic              ready_out;
  logic signed [7:0] pixel_out;
  logic              all_done;

  modport slave (
    input  valid_in, pixel_in, ready_out,
    output ready_in, valid_out, pixel_out, all_done
  );

  modport master (
    output valid_in, pixel_in, ready_out,
    input  ready_in, valid_out, pixel_out, all_done
  );
endinterface

// File: rtl/unpool_engine.sv
// 2x nearest-neighbour upsampler (zero-insertion when UNPOOL_ZERO_FILL_EN is defined); 1-cycle input-to-output
// latency; output register holds under backpressure, input stalls while replaying the odd output rows.
module unpool_engine #(
  parameter  int IN_DIM  = 14,
  localparam int OUT_DIM = IN_DIM * 2
) (
  input  logic           clk,
  input  logic           rst_n,
  unpool_engine_if.slave io
);

  localparam int CW = $clog2(IN_DIM) + 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IN_DIM - 1);
  localparam logic [CW:0]   OUT_LAST = (CW + 1)'(OUT_DIM - 1);

  typedef enum logic [1:0] {FILL, REPLAY, DONE} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     in_col_q, in_col_d;
  logic [CW-1:0]     col_q, col_d;
  logic [CW-1:0]     in_row_q, in_row_d;
  logic              phase_q, phase_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic signed [7:0] pix_q, pix_d;

  logic              ready_in;
  logic              in_xfer;
  logic              out_xfer;
  logic              last_out;
  logic [CW:0]       out_col;
  logic [CW-1:0]     col_nxt;
  logic [CW-1:0]     in_col_nxt;
  logic signed [7:0] rd_pix;
  logic signed [7:0] copy_pix;

  // Output column of the held pixel is simply {input column, copy phase}.
  assign out_col    = {col_q, phase_q};
  assign last_out   = (out_col == OUT_LAST);
  assign col_nxt    = (col_q == COL_LAST) ? '0 : col_q + CW'(1);
  assign in_col_nxt = (in_col_q == COL_LAST) ? '0 : in_col_q + CW'(1);
  assign out_xfer   = valid_q && io.ready_out;
  assign in_xfer    = io.valid_in && ready_in;

  always_comb begin
    ready_in = 1'b0;
    case (state_q)
      FILL:    ready_in = !valid_q || (io.ready_out && phase_q && !last_out);
      DONE:    ready_in = 1'b1;
      default: ready_in = 1'b0;
    endcase
  end

`ifdef UNPOOL_ZERO_FILL_EN
  assign rd_pix   = '0;
  assign copy_pix = '0;
`else
  localparam int AW = (IN_DIM > 1) ? $clog2(IN_DIM) : 1;

  logic signed [7:0] line_buf_q [1 << AW];
  logic [AW-1:0]     rd_idx;

  // Entering REPLAY needs column 0; inside REPLAY the next column is prefetched.
  assign rd_idx   = (state_q == REPLAY) ? col_nxt[AW-1:0] : '0;
  assign rd_pix   = line_buf_q[rd_idx];
  assign copy_pix = pix_q;

  always_ff @(posedge clk) begin
    if (in_xfer) begin
      line_buf_q[in_col_q[AW-1:0]] <= io.pixel_in;
    end
  end
`endif

  always_comb begin
    state_d  = state_q;
    in_col_d = in_col_q;
    col_d    = col_q;
    in_row_d = in_row_q;
    phase_d  = phase_q;
    valid_d  = valid_q;
    done_d   = done_q;
    pix_d    = pix_q;

    case (state_q)
      FILL: begin
        if (out_xfer) begin
          if (!phase_q) begin
            phase_d = 1'b1;
            pix_d   = copy_pix;
          end else if (last_out) begin
            state_d = REPLAY;
            col_d   = '0;
            phase_d = 1'b0;
            pix_d   = rd_pix;
          end else begin
            valid_d = 1'b0;
          end
        end
      end
      REPLAY: begin
        if (out_xfer) begin
          if (!phase_q) begin
            phase_d = 1'b1;
            pix_d   = copy_pix;
          end else if (last_out) begin
            valid_d = 1'b0;
            phase_d = 1'b0;
            col_d   = '0;
            if (in_row_q == COL_LAST) begin
              state_d  = DONE;
              done_d   = 1'b1;
              in_row_d = '0;
            end else begin
              state_d  = FILL;
              in_row_d = in_row_q + CW'(1);
            end
          end else begin
            col_d   = col_nxt;
            phase_d = 1'b0;
            pix_d   = rd_pix;
          end
        end
      end
      default: ;
    endcase

    // A new pixel overrides the drop of a finished second copy, so FILL streams without bubbles.
    if (in_xfer) begin
      state_d  = FILL;
      done_d   = 1'b0;
      valid_d  = 1'b1;
      phase_d  = 1'b0;
      pix_d    = io.pixel_in;
      col_d    = in_col_q;
      in_col_d = in_col_nxt;
      if (state_q == DONE) begin
        in_row_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= FILL;
      in_col_q <= '0;
      col_q    <= '0;
      in_row_q <= '0;
      phase_q  <= 1'b0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      pix_q    <= '0;
    end else begin
      state_q  <= state_d;
      in_col_q <= in_col_d;
      col_q    <= col_d;
      in_row_q <= in_row_d;
      phase_q  <= phase_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      pix_q    <= pix_d;
    end
  end

  assign io.ready_in  = ready_in;
  assign io.valid_out = valid_q;
  assign io.pixel_out = pix_q;
  assign io.all_done  = done_q;

endmodule

// File: tb/tb_unpool_engine.sv
// Bench for unpool_engine at IN_DIM=2: expected frames are queued on send and popped per output transfer.
module tb_unpool_engine;
  localparam int IN_DIM  = 2;
  localparam int OUT_DIM = IN_DIM * 2;
  localparam int NPIX    = IN_DIM * IN_DIM;
`ifdef UNPOOL_ZERO_FILL_EN
  localparam bit ZF = 1'b1;
`else
  localparam bit ZF = 1'b0;
`endif

  logic clk;
  logic rst_n;
  unpool_engine_if ifc();

  unpool_engine #(.IN_DIM(IN_DIM)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (ifc)
  );

  int checks   = 0;
  int failures = 0;
  int sb[$];
  int out_cnt  = 0;
  int rdy_mode = 0;
  bit stalled  = 1'b0;
  int stall_pix;
  bit abort    = 1'b0;
  int frame[NPIX];

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  // Downstream readiness: 0 = always ready, 1 = toggling, other = random.
  initial begin
    ifc.ready_out = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       ifc.ready_out = 1'b1;
        1:       ifc.ready_out = ~ifc.ready_out;
        default: ifc.ready_out = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (stalled) begin
          chk("stall_vld", ifc.valid_out, 1);
          chk("stall_pix", ifc.pixel_out, stall_pix);
        end
        stalled   = ifc.valid_out && !ifc.ready_out;
        stall_pix = ifc.pixel_out;
        if (ifc.valid_out && (((out_cnt % (OUT_DIM * OUT_DIM)) / OUT_DIM) % 2 == 1))
          chk("rdy_in_replay", ifc.ready_in, 0);
        if (ifc.valid_out && ifc.ready_out) begin
          if (sb.size() == 0) chk("sb_underrun", sb.size(), 1);
          else chk($sformatf("out[%0d]", out_cnt), ifc.pixel_out, sb.pop_front());
          out_cnt++;
        end
      end else begin
        stalled = 1'b0;
      end
    end
  end

  task automatic send_frame(input int p[NPIX], input int max_gap);
    int  gap;
    bit  accepted;
    for (int r = 0; r < IN_DIM; r++) begin
      for (int c = 0; c < IN_DIM; c++) begin
        sb.push_back(p[r*IN_DIM + c]);
        sb.push_back(ZF ? 0 : p[r*IN_DIM + c]);
      end
      for (int c = 0; c < IN_DIM; c++) begin
        sb.push_back(ZF ? 0 : p[r*IN_DIM + c]);
        sb.push_back(ZF ? 0 : p[r*IN_DIM + c]);
      end
    end
    for (int i = 0; i < NPIX; i++) begin
      gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
      ifc.valid_in = 1'b1;
      ifc.pixel_in = 8'(p[i]);
      accepted = 1'b0;
      for (int w = 0; w < 200 && !accepted && !abort; w++) begin
        @(negedge clk);
        if (ifc.ready_in) accepted = 1'b1;
        @(posedge clk);
        #1;
      end
      ifc.valid_in = 1'b0;
      if (abort) return;
      chk($sformatf("in_accept[%0d]", i), accepted, 1);
      if (i == 0) chk("done_clr", ifc.all_done, 0);
    end
  endtask

  task automatic end_frame(input string tag);
    for (int w = 0; w < 500 && sb.size() != 0; w++) begin
      @(negedge clk);
      #1;
    end
    chk({tag, "_drain"}, sb.size(), 0);
    chk({tag, "_done_early"}, ifc.all_done, 0);
    @(posedge clk);
    #1;
    chk({tag, "_done"}, ifc.all_done, 1);
  endtask

  initial begin
    rst_n        = 1'b1;
    ifc.valid_in = 1'b0;
    ifc.pixel_in = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid_out", ifc.valid_out, 0);
    chk("rst_pixel_out", ifc.pixel_out, 0);
    chk("rst_all_done", ifc.all_done, 0);
    chk("rst_ready_in", ifc.ready_in, 1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_ready_in", ifc.ready_in, 1);

    frame = '{1, -2, 3, 4};
    send_frame(frame, 0);
    end_frame("f_basic");

    rdy_mode = 1;
    send_frame(frame, 0);
    end_frame("f_toggle");

    rdy_mode = 0;
    frame = '{-128, 127, 0, -1};
    send_frame(frame, 0);
    end_frame("f_sign");

    frame = '{5, 6, 7, 8};
    send_frame(frame, 0);
    end_frame("f_b2b");

    rdy_mode = 2;
    frame = '{-7, 100, -100, 42};
    send_frame(frame, 3);
    end_frame("f_rand");

    rdy_mode = 0;
    frame = '{1, -2, 3, 4};
    abort = 1'b0;
    fork
      send_frame(frame, 0);
      begin
        for (int w = 0; w < 300 && out_cnt % (OUT_DIM * OUT_DIM) < 6; w++) begin
          @(negedge clk);
          #1;
        end
        chk("pre_rst_cnt", out_cnt % (OUT_DIM * OUT_DIM), 6);
        @(posedge clk);
        #2;
        chk("pre_rst_vld", ifc.valid_out, 1);
        abort = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid_out", ifc.valid_out, 0);
        chk("midrst_all_done", ifc.all_done, 0);
        chk("midrst_pixel_out", ifc.pixel_out, 0);
        repeat (2) @(posedge clk);
        #1;
        sb.delete();
        out_cnt = 0;
        rst_n   = 1'b1;
      end
    join
    abort = 1'b0;

    frame = '{9, 8, 7, 6};
    send_frame(frame, 0);
    end_frame("f_after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
